yarp_branch_predict_unit: RTL and testbench
===========================================

YARP_BRANCH_PREDICT_UNIT -- requirements
Module: yarp_branch_predict_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/PC width (>=32).
REQ-002 Parameter BHT_DEPTH, default 64, number of branch-history entries (power of 2, >=2).
REQ-003 Parameter CNT_W, default 2, saturating-counter width per entry (>=1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall_i  input  1  pipeline stall; freezes all state.
REQ-007 resolve_valid_i  input  1  instruction present in resolve stage.
REQ-008 is_b_type_i  input  1  instruction is a conditional branch.
REQ-009 func3_i  input  3  branch funct3.
REQ-010 opr_a_i, opr_b_i  input  XLEN  source operands.
REQ-011 pc_i, imm_i  input  XLEN  branch PC and sign-extended B-immediate.
REQ-012 pred_taken_i  input  1  prediction that fetch used for this branch.
REQ-013 lookup_pc_i  input  XLEN  fetch-stage PC for prediction.
REQ-014 lookup_taken_o  output  1  combinational prediction for lookup_pc_i.
REQ-015 valid_o  output  1  registered result valid.
REQ-016 branch_taken_o  output  1  registered resolved outcome.
REQ-017 mispredict_o  output  1  registered misprediction flag.
REQ-018 illegal_o  output  1  registered flag for reserved funct3.
REQ-019 redirect_pc_o  output  XLEN  registered correct next PC.
REQ-020 mispredict_cnt_o  output  32  saturating misprediction count.

Function
REQ-021 Compare SHALL follow funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; signed compares use full XLEN two's complement.
REQ-022 funct3 010/011 with resolve_valid_i&is_b_type_i SHALL yield taken=0, illegal=1, mispredict=0, no BHT update.
REQ-023 Taken target SHALL be (pc_i+imm_i) mod 2^XLEN; not-taken next PC SHALL be (pc_i+4) mod 2^XLEN.
REQ-024 A resolve event = resolve_valid_i & is_b_type_i & !stall_i; latency from inputs to registered outputs SHALL be exactly 1 cycle.
REQ-025 On resolve event: valid_o=1, branch_taken_o=outcome, redirect_pc_o=taken?target:pc+4, mispredict_o=(outcome!=pred_taken_i).
REQ-026 When !stall_i and no resolve event: valid_o, branch_taken_o, mispredict_o, illegal_o SHALL be 0; redirect_pc_o SHALL be 0.
REQ-027 When stall_i=1: all registered outputs, BHT and counter SHALL hold their values (regardless of other inputs).
REQ-028 BHT index SHALL be PC[log2(BHT_DEPTH)+1:2] for both lookup and update.
REQ-029 On legal resolve event, indexed counter SHALL increment if taken, decrement if not, saturating at 2^CNT_W-1 and 0.
REQ-030 lookup_taken_o SHALL equal MSB of counter at lookup index, reflecting state before any same-cycle update (read-before-write).
REQ-031 mispredict_cnt_o SHALL increment by 1 on each resolve event with mispredict, saturating at 0xFFFF_FFFF; registered, same cycle as mispredict_o.

Reset
REQ-032 reset SHALL clear all outputs and mispredict_cnt_o to 0 on the next edge, overriding stall_i and any resolve event.
REQ-033 reset SHALL set every BHT counter to weakly-not-taken, 2^(CNT_W-1)-1 (01 for CNT_W=2; 0 for CNT_W=1), within one cycle.
REQ-034 Reset asserted mid-operation SHALL discard the in-flight resolve event (no BHT or counter update).

Verification
REQ-035 After reset, lookup_pc_i=0x100 -> lookup_taken_o=0; all outputs 0, mispredict_cnt_o=0.
REQ-036 BLT a=0xFFFF_FFFF(-1), b=1, pc=0x200, imm=0x40, pred=0 -> next cycle taken=1, redirect=0x240, mispredict=1, count=1; BLTU same operands -> taken=0, redirect=0x204.
REQ-037 Two taken resolves at pc=0x100 (CNT_W=2) -> counter 01->10->11, lookup_taken_o=1 after first; third taken stays 11; three not-taken -> 00, fourth stays 00.
REQ-038 Resolve with stall_i=1 for 3 cycles -> outputs, BHT, count unchanged; release -> result appears 1 cycle later.
REQ-039 funct3=010, pred=1 -> illegal_o=1, taken=0, mispredict=0, BHT entry unchanged; pc=0xFFFF_FFFC, imm=8, BEQ equal -> redirect=0x0000_0004 (wrap).
REQ-040 Same-cycle lookup and update on index 5 -> lookup_taken_o shows old MSB; reset during resolve event -> outputs 0, BHT at weakly-not-taken.

Source files
------------

// File: rtl/yarp_branch_predict_unit.sv
// Branch resolve unit with a bimodal branch-history table for fetch-stage prediction.
// Resolves conditional branches, flags mispredictions and counts them.
module yarp_branch_predict_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            resolve_valid_i,
    input  logic            is_b_type_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            lookup_taken_o,
    output logic            valid_o,
    output logic            branch_taken_o,
    output logic            mispredict_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [31:0]     mispredict_cnt_o
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((32'd1 << (CNT_W - 1)) - 32'd1);

    logic [CNT_W-1:0] r_bht [BHT_DEPTH];
    logic             r_valid;
    logic             r_taken;
    logic             r_mispredict;
    logic             r_illegal;
    logic [XLEN-1:0]  r_redirect;
    logic [31:0]      r_cnt;

    logic             w_eq;
    logic             w_lt;
    logic             w_ltu;
    logic             w_taken;
    logic             w_illegal;
    logic             w_event;
    logic             w_update;
    logic             w_mispredict;
    logic [IDX_W-1:0] w_lookup_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [CNT_W-1:0] w_upd_cnt;
    logic [XLEN-1:0]  w_next_pc;
    logic             w_unused;

    assign w_eq  = (opr_a_i == opr_b_i);
    assign w_lt  = ($signed(opr_a_i) < $signed(opr_b_i));
    assign w_ltu = (opr_a_i < opr_b_i);

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (func3_i)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = !w_eq;
            3'b100:  w_taken = w_lt;
            3'b101:  w_taken = !w_lt;
            3'b110:  w_taken = w_ltu;
            3'b111:  w_taken = !w_ltu;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_event      = resolve_valid_i & is_b_type_i & !stall_i;
    assign w_update     = w_event & !w_illegal;
    assign w_mispredict = !w_illegal & (w_taken != pred_taken_i);
    assign w_next_pc    = w_taken ? (pc_i + imm_i) : (pc_i + XLEN'(4));

    assign w_lookup_idx   = lookup_pc_i[IDX_W+1:2];
    assign w_upd_idx      = pc_i[IDX_W+1:2];
    assign lookup_taken_o = r_bht[w_lookup_idx][CNT_W-1];

    // Two-sided saturating step of the indexed counter
    always_comb begin
        w_upd_cnt = r_bht[w_upd_idx];
        if (w_taken && r_bht[w_upd_idx] != CNT_MAX) begin
            w_upd_cnt = r_bht[w_upd_idx] + CNT_W'(1);
        end else if (!w_taken && r_bht[w_upd_idx] != '0) begin
            w_upd_cnt = r_bht[w_upd_idx] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_illegal    <= 1'b0;
            r_redirect   <= '0;
            r_cnt        <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= CNT_WNT;
            end
        end else if (!stall_i) begin
            r_valid      <= w_event;
            r_taken      <= w_event & w_taken;
            r_mispredict <= w_event & w_mispredict;
            r_illegal    <= w_event & w_illegal;
            r_redirect   <= w_event ? w_next_pc : '0;
            if (w_event && w_mispredict && r_cnt != 32'hFFFF_FFFF) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_update) begin
                r_bht[w_upd_idx] <= w_upd_cnt;
            end
        end
    end

    assign valid_o          = r_valid;
    assign branch_taken_o   = r_taken;
    assign mispredict_o     = r_mispredict;
    assign illegal_o        = r_illegal;
    assign redirect_pc_o    = r_redirect;
    assign mispredict_cnt_o = r_cnt;

    // Only the index bits of the lookup PC feed the table
    assign w_unused = ^{lookup_pc_i[XLEN-1:IDX_W+2], lookup_pc_i[1:0]};

endmodule

// File: tb/tb_yarp_branch_predict_unit.sv
// Scoreboard bench for yarp_branch_predict_unit: directed branches with hand-computed results.
module tb_yarp_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        resolve_valid_i;
    logic        is_b_type_i;
    logic [2:0]  func3_i;
    logic [31:0] opr_a_i, opr_b_i, pc_i, imm_i, lookup_pc_i;
    logic        pred_taken_i;
    logic        lookup_taken_o, valid_o, branch_taken_o, mispredict_o, illegal_o;
    logic [31:0] redirect_pc_o, mispredict_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        taken;
        logic        mis;
        logic        ill;
        logic [31:0] redir;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    logic stall_at_edge = 1'b0;
    logic reset_at_edge = 1'b0;

    yarp_branch_predict_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall_i),
        .resolve_valid_i  (resolve_valid_i),
        .is_b_type_i      (is_b_type_i),
        .func3_i          (func3_i),
        .opr_a_i          (opr_a_i),
        .opr_b_i          (opr_b_i),
        .pc_i             (pc_i),
        .imm_i            (imm_i),
        .pred_taken_i     (pred_taken_i),
        .lookup_pc_i      (lookup_pc_i),
        .lookup_taken_o   (lookup_taken_o),
        .valid_o          (valid_o),
        .branch_taken_o   (branch_taken_o),
        .mispredict_o     (mispredict_o),
        .illegal_o        (illegal_o),
        .redirect_pc_o    (redirect_pc_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        stall_at_edge <= stall_i;
        reset_at_edge <= reset;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every fresh valid result is matched against the oldest expectation
    always @(negedge clk) begin
        if (valid_o === 1'b1 && !stall_at_edge && !reset_at_edge) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid_o=1 expected no result pending");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_taken", {31'd0, branch_taken_o}, {31'd0, e.taken});
                chk("sb_mispredict", {31'd0, mispredict_o}, {31'd0, e.mis});
                chk("sb_illegal", {31'd0, illegal_o}, {31'd0, e.ill});
                chk("sb_redirect", redirect_pc_o, e.redir);
                chk("sb_count", mispredict_cnt_o, e.cnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        resolve_valid_i = 1'b0;
        is_b_type_i     = 1'b0;
        stall_i         = 1'b0;
        step();
    endtask

    task automatic set_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        resolve_valid_i = 1'b1;
        is_b_type_i     = 1'b1;
        func3_i         = f3;
        opr_a_i         = a;
        opr_b_i         = b;
        pc_i            = pc;
        imm_i           = imm;
        pred_taken_i    = pred;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                         input logic e_taken, input logic e_mis, input logic e_ill,
                         input logic [31:0] e_redir, input logic [31:0] e_cnt);
        exp_t e;
        set_branch(f3, a, b, pc, imm, pred);
        stall_i = 1'b0;
        e.taken = e_taken;
        e.mis   = e_mis;
        e.ill   = e_ill;
        e.redir = e_redir;
        e.cnt   = e_cnt;
        exp_q.push_back(e);
        step();
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_valid"}, {31'd0, valid_o}, 32'd0);
        chk({name, "_taken"}, {31'd0, branch_taken_o}, 32'd0);
        chk({name, "_mispredict"}, {31'd0, mispredict_o}, 32'd0);
        chk({name, "_illegal"}, {31'd0, illegal_o}, 32'd0);
        chk({name, "_redirect"}, redirect_pc_o, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall_i = 1'b0; resolve_valid_i = 1'b0; is_b_type_i = 1'b0;
        func3_i = 3'b000; opr_a_i = '0; opr_b_i = '0; pc_i = '0; imm_i = '0;
        pred_taken_i = 1'b0; lookup_pc_i = 32'h100;
        step(); step();
        reset = 1'b0;
        #1;
        chk_quiet("reset");
        chk("reset_count", mispredict_cnt_o, 32'd0);
        chk("reset_lookup", {31'd0, lookup_taken_o}, 32'd0);

        // Signed vs unsigned less-than on the same operands
        issue(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 32'h240, 32'd1);
        issue(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, 32'd1);
        idle();
        chk_quiet("idle");
        resolve_valid_i = 1'b1; is_b_type_i = 1'b0;
        step();
        chk_quiet("not_branch");

        // Counter walk at pc 0x100: 01->10->11->11, then down to 00 and held
        lookup_pc_i = 32'h100;
        issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h10, 1'b0, 1'b1, 1'b1, 1'b0, 32'h110, 32'd2);
        chk("walk_t1", {31'd0, lookup_taken_o}, 32'd1);
        issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h110, 32'd2);
        chk("walk_t2", {31'd0, lookup_taken_o}, 32'd1);
        issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h110, 32'd2);
        chk("walk_t3", {31'd0, lookup_taken_o}, 32'd1);
        issue(3'b001, 32'd5, 32'd5, 32'h100, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'd3);
        chk("walk_n1", {31'd0, lookup_taken_o}, 32'd1);
        issue(3'b001, 32'd5, 32'd5, 32'h100, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'd4);
        chk("walk_n2", {31'd0, lookup_taken_o}, 32'd0);
        issue(3'b001, 32'd5, 32'd5, 32'h100, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 32'd4);
        issue(3'b001, 32'd5, 32'd5, 32'h100, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 32'd4);
        issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h110, 32'd4);
        chk("walk_floor", {31'd0, lookup_taken_o}, 32'd0);

        // Stall holds outputs, table and count for three cycles
        lookup_pc_i = 32'h300;
        issue(3'b000, 32'd7, 32'd7, 32'h300, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 32'h320, 32'd4);
        set_branch(3'b001, 32'd7, 32'd7, 32'h300, 32'h20, 1'b1);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", {31'd0, valid_o}, 32'd1);
            chk("stall_taken", {31'd0, branch_taken_o}, 32'd1);
            chk("stall_redirect", redirect_pc_o, 32'h320);
            chk("stall_count", mispredict_cnt_o, 32'd4);
            chk("stall_lookup", {31'd0, lookup_taken_o}, 32'd1);
        end
        issue(3'b001, 32'd7, 32'd7, 32'h300, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h304, 32'd5);
        chk("release_lookup", {31'd0, lookup_taken_o}, 32'd0);

        // Reserved funct3 leaves the table alone
        lookup_pc_i = 32'h400;
        issue(3'b000, 32'd3, 32'd3, 32'h400, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h408, 32'd5);
        chk("pre_illegal_lookup", {31'd0, lookup_taken_o}, 32'd1);
        issue(3'b010, 32'd3, 32'd4, 32'h400, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h404, 32'd5);
        issue(3'b011, 32'd3, 32'd3, 32'h400, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1, 32'h404, 32'd5);
        chk("illegal_lookup", {31'd0, lookup_taken_o}, 32'd1);

        // Target wrap and the ge compares
        issue(3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 32'd5);
        issue(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h500, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h504, 32'd6);
        issue(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h500, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'd6);

        // Same-cycle lookup and update on index 5 sees the old counter
        lookup_pc_i = 32'h14;
        set_branch(3'b000, 32'd1, 32'd1, 32'h14, 32'h20, 1'b0);
        #1;
        chk("rbw_before", {31'd0, lookup_taken_o}, 32'd0);
        issue(3'b000, 32'd1, 32'd1, 32'h14, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 32'h34, 32'd7);
        chk("rbw_after", {31'd0, lookup_taken_o}, 32'd1);

        // Reset during a resolve event discards it
        set_branch(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h14, 32'h40, 1'b0);
        reset = 1'b1;
        step();
        chk_quiet("rst_mid");
        chk("rst_mid_count", mispredict_cnt_o, 32'd0);
        chk("rst_mid_lookup", {31'd0, lookup_taken_o}, 32'd0);
        reset = 1'b0;
        idle();
        chk("post_rst_lookup", {31'd0, lookup_taken_o}, 32'd0);
        chk("post_rst_count", mispredict_cnt_o, 32'd0);
        idle();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
